// File: rtl/sar_adc_scan_if.sv
// CPU-side control and tagged-result bundle of sar_adc_scan.
// master = CPU I/O register block, slave = converter.
interface sar_adc_scan_if #(
  parameter int BITS     = 8,
  parameter int CHANNELS = 4
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                start;
  logic                cont_en;
  logic [CHANNELS-1:0] ch_en;
  logic                busy;
  logic [BITS-1:0]     result;
  logic [CH_W-1:0]     result_ch;
  logic                result_valid;

  modport master (
    output start, cont_en, ch_en,
    input  busy, result, result_ch, result_valid
  );

  modport slave (
    input  start, cont_en, ch_en,
    output busy, result, result_ch, result_valid
  );
endinterface

// File: rtl/sar_adc_scan.sv
// Multi-channel PWM-DAC SAR ADC scanner with oversampling; one result per 2**OSR_LOG2 conversions.
// Latency (SAMPLE_PERIODS+BITS*BIT_PERIODS)*PWM_PERIOD per conversion; no backpressure, result_valid is a 1-cycle strobe.
module sar_adc_scan #(
  parameter int BITS           = 8,
  parameter int CHANNELS       = 4,
  parameter int PWM_PERIOD     = 255,
  parameter int SAMPLE_PERIODS = 100,
  parameter int BIT_PERIODS    = 100,
  parameter int OSR_LOG2       = 0,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  sar_adc_scan_if.slave   cpu,
  input  logic            adc_cmp,
  output logic            adc_sh_ctl,
  output logic            adc_dac_pwm,
  output logic [CH_W-1:0] mux_sel
);

  localparam int PW    = $clog2(PWM_PERIOD);
  localparam int CW    = (PW > BITS) ? PW : BITS;
  localparam int PMAX  = (SAMPLE_PERIODS > BIT_PERIODS) ? SAMPLE_PERIODS : BIT_PERIODS;
  localparam int PERW  = $clog2(PMAX + 1);
  localparam int BIW   = $clog2(BITS);
  localparam int AW    = BITS + OSR_LOG2;
  localparam int OW    = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
  localparam int OSR_N = 1 << OSR_LOG2;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;

  state_t          state;
  logic [PW-1:0]   pwm_cnt;
  logic            boundary;
  logic [1:0]      cmp_sync;
  logic            cmp_s;
  logic [BITS-1:0] sar;
  logic [BITS-1:0] sar_upd;
  logic [BIW-1:0]  bit_idx;
  logic [PERW-1:0] per_cnt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_sum;
  logic [OW-1:0]   osr_cnt;
  logic            osr_last;
  logic [CH_W-1:0] cur_ch;
  logic [CH_W-1:0] next_ch;
  logic [CH_W-1:0] cur_inc;
  logic [CH_W-1:0] base_ch;
  logic [CH_W-1:0] sel_ch;
  logic [CH_W:0]   j;
  logic            any_en;
  logic            start_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else if (boundary) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmp_sync <= '0;
    else cmp_sync <= {cmp_sync[0], adc_cmp};
  end

  assign boundary    = (pwm_cnt == PW'(PWM_PERIOD - 1));
  assign cmp_s       = cmp_sync[1];
  assign adc_dac_pwm = (CW'(pwm_cnt) < CW'(sar));
  assign mux_sel     = cur_ch;
  assign any_en      = |cpu.ch_en;
  assign cur_inc     = (cur_ch == CH_W'(CHANNELS - 1)) ? '0 : cur_ch + CH_W'(1);
  assign base_ch     = (state == IDLE) ? next_ch : cur_inc;
  assign osr_last    = (osr_cnt == OW'(OSR_N - 1));
  assign acc_sum     = acc + AW'(sar_upd);

  // Scan downwards so the enabled channel nearest base_ch (with wrap) wins.
  always_comb begin
    sel_ch = '0;
    j      = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      j = {1'b0, base_ch} + (CH_W+1)'(i);
      if (j >= (CH_W+1)'(CHANNELS)) j = j - (CH_W+1)'(CHANNELS);
      if (cpu.ch_en[j[CH_W-1:0]]) sel_ch = j[CH_W-1:0];
    end
  end

  always_comb begin
    sar_upd          = sar;
    sar_upd[bit_idx] = cmp_s;
    if (bit_idx != '0) sar_upd[bit_idx - BIW'(1)] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      sar              <= '0;
      bit_idx          <= '0;
      per_cnt          <= '0;
      acc              <= '0;
      osr_cnt          <= '0;
      cur_ch           <= '0;
      next_ch          <= '0;
      start_pend       <= 1'b0;
      adc_sh_ctl       <= 1'b0;
      cpu.busy         <= 1'b0;
      cpu.result       <= '0;
      cpu.result_ch    <= '0;
      cpu.result_valid <= 1'b0;
    end else begin
      cpu.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.start) start_pend <= 1'b1;
          if (boundary && (start_pend || cpu.cont_en) && any_en) begin
            state      <= SAMPLE;
            cpu.busy   <= 1'b1;
            start_pend <= 1'b0;
            cur_ch     <= sel_ch;
            acc        <= '0;
            osr_cnt    <= '0;
            per_cnt    <= '0;
          end
        end
        SAMPLE: begin
          if (boundary) begin
            if (per_cnt == PERW'(SAMPLE_PERIODS - 1)) begin
              state      <= CONVERT;
              adc_sh_ctl <= 1'b1;
              sar        <= {1'b1, {(BITS-1){1'b0}}};
              bit_idx    <= BIW'(BITS - 1);
              per_cnt    <= '0;
            end else begin
              per_cnt <= per_cnt + PERW'(1);
            end
          end
        end
        CONVERT: begin
          if (boundary) begin
            if (per_cnt != PERW'(BIT_PERIODS - 1)) begin
              per_cnt <= per_cnt + PERW'(1);
            end else begin
              per_cnt <= '0;
              if (bit_idx != '0) begin
                sar     <= sar_upd;
                bit_idx <= bit_idx - BIW'(1);
              end else begin
                // Conversion done: the DAC code is irrelevant while tracking.
                adc_sh_ctl <= 1'b0;
                sar        <= '0;
                if (!osr_last) begin
                  acc     <= acc_sum;
                  osr_cnt <= osr_cnt + OW'(1);
                  state   <= SAMPLE;
                end else begin
                  cpu.result       <= acc_sum[AW-1:OSR_LOG2];
                  cpu.result_ch    <= cur_ch;
                  cpu.result_valid <= 1'b1;
                  next_ch          <= cur_inc;
                  if (cpu.cont_en && any_en) begin
                    state   <= SAMPLE;
                    cur_ch  <= sel_ch;
                    acc     <= '0;
                    osr_cnt <= '0;
                  end else begin
                    state    <= IDLE;
                    cpu.busy <= 1'b0;
                  end
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_scan.sv
// Directed bench for sar_adc_scan: two instances (OSR_LOG2=0 and 2) with a moving-average DAC
// and comparator model; expected results are hand-computed SAR outcomes.
module tb_sar_adc_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  sar_adc_scan_if #(.BITS(4), .CHANNELS(4)) m ();
  sar_adc_scan_if #(.BITS(4), .CHANNELS(4)) o ();

  logic       adc_cmp, adc_sh_ctl, adc_dac_pwm;
  logic [1:0] mux_sel;
  logic       o_cmp, o_sh, o_pwm;
  logic [1:0] o_mux;

  int vin [4];
  int vin_o;
  logic [14:0] win   = '0;
  logic [14:0] win_o = '0;

  // Vdac = PWM duty averaged over the last 15 cycles.
  always @(posedge clk) begin
    win   <= {win[13:0], adc_dac_pwm};
    win_o <= {win_o[13:0], o_pwm};
  end
  assign adc_cmp = (vin[mux_sel] >= $countones(win));
  assign o_cmp   = (vin_o >= $countones(win_o));

  sar_adc_scan #(.BITS(4), .CHANNELS(4), .PWM_PERIOD(15), .SAMPLE_PERIODS(2),
                 .BIT_PERIODS(2), .OSR_LOG2(0)) dut (
    .clk(clk), .rst_n(rst_n), .cpu(m), .adc_cmp(adc_cmp),
    .adc_sh_ctl(adc_sh_ctl), .adc_dac_pwm(adc_dac_pwm), .mux_sel(mux_sel));

  sar_adc_scan #(.BITS(4), .CHANNELS(4), .PWM_PERIOD(15), .SAMPLE_PERIODS(2),
                 .BIT_PERIODS(2), .OSR_LOG2(2)) dut_osr (
    .clk(clk), .rst_n(rst_n), .cpu(o), .adc_cmp(o_cmp),
    .adc_sh_ctl(o_sh), .adc_dac_pwm(o_pwm), .mux_sel(o_mux));

  int n_chk  = 0;
  int n_fail = 0;
  int per_hi [10];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start_m();
    @(negedge clk) m.start = 1'b1;
    @(negedge clk) m.start = 1'b0;
  endtask

  // Returns at the first negedge with busy high; lat = posedges after start was sampled.
  task automatic wait_busy_m(input string tag, output bit ok);
    int lat;
    lat = 0;
    while (!m.busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    ok = m.busy;
    check({tag, "_lat_in_range"}, int'(lat >= 1 && lat <= 15), 1);
  endtask

  task automatic run_single(input string tag, input int exp_res, input int exp_ch);
    bit ok;
    int k;
    pulse_start_m();
    wait_busy_m(tag, ok);
    if (!ok) return;
    for (int p = 0; p < 10; p++) per_hi[p] = 0;
    k = 0;
    while (!m.result_valid && k < 200) begin
      if (k == 0)  check({tag, "_sh_sample"}, int'(adc_sh_ctl), 0);
      if (k == 30) check({tag, "_sh_convert"}, int'(adc_sh_ctl), 1);
      if (k < 150) per_hi[k/15] += int'(adc_dac_pwm);
      @(negedge clk);
      k++;
    end
    check({tag, "_valid_delay"}, k, 150);
    check({tag, "_result"}, int'(m.result), exp_res);
    check({tag, "_result_ch"}, int'(m.result_ch), exp_ch);
    check({tag, "_busy_fall"}, int'(m.busy), 0);
    @(negedge clk);
    check({tag, "_valid_width"}, int'(m.result_valid), 0);
  endtask

  int exp_duty [10] = '{0, 0, 8, 8, 12, 12, 10, 10, 11, 11};
  int exp_t    [4]  = '{150, 300, 450, 600};
  int exp_rc   [4]  = '{1, 3, 1, 3};
  int exp_rr   [4]  = '{3, 15, 3, 15};

  initial begin
    bit   ok;
    int   k, cnt_pwm, cnt_busy, cnt_valid, cnt_res, nres;
    int   t [4], rr [4], rc [4];
    logic [1:0] prev_mux;

    for (int i = 0; i < 4; i++) vin[i] = 0;
    vin_o     = 0;
    m.start   = 1'b0; m.cont_en = 1'b0; m.ch_en = '0;
    o.start   = 1'b0; o.cont_en = 1'b0; o.ch_en = '0;
    rst_n     = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_busy", int'(m.busy), 0);
    check("rst_valid", int'(m.result_valid), 0);
    check("rst_result", int'(m.result), 0);
    check("rst_result_ch", int'(m.result_ch), 0);
    check("rst_sh", int'(adc_sh_ctl), 0);
    check("rst_pwm", int'(adc_dac_pwm), 0);
    check("rst_mux", int'(mux_sel), 0);
    rst_n = 1'b1;
    cnt_pwm = 0; cnt_busy = 0; cnt_valid = 0; cnt_res = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt_pwm   += int'(adc_dac_pwm);
      cnt_busy  += int'(m.busy);
      cnt_valid += int'(m.result_valid);
      cnt_res   += int'(m.result != 0) + int'(adc_sh_ctl);
    end
    check("idle_pwm_cycles", cnt_pwm, 0);
    check("idle_busy_cycles", cnt_busy, 0);
    check("idle_valid_cycles", cnt_valid, 0);
    check("idle_result_sh", cnt_res, 0);

    // Single shot on ch0 with PWM duty trace
    m.ch_en = 4'b0001;
    vin[0]  = 11;
    run_single("single11", 11, 0);
    for (int p = 0; p < 10; p++) check($sformatf("duty_period%0d", p), per_hi[p], exp_duty[p]);

    // Extremes
    vin[0] = 0;
    run_single("vin0", 0, 0);
    vin[0] = 15;
    run_single("vin15", 15, 0);

    // Continuous scan over ch1/ch3; cont_en dropped after the third result
    m.ch_en   = 4'b1010;
    vin[1]    = 3;
    vin[3]    = 15;
    m.cont_en = 1'b1;
    k = 0;
    while (!m.busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("scan_started", int'(m.busy), 1);
    check("scan_first_mux", int'(mux_sel), 1);
    for (int i = 0; i < 4; i++) begin t[i] = -1; rr[i] = -1; rc[i] = -1; end
    prev_mux = mux_sel;
    nres = 0;
    k = 0;
    while (nres < 4 && k < 700) begin
      if (mux_sel != prev_mux) check($sformatf("mux_change_off_boundary_k%0d", k), k % 15, 0);
      prev_mux = mux_sel;
      if (m.result_valid) begin
        t[nres]  = k;
        rr[nres] = int'(m.result);
        rc[nres] = int'(m.result_ch);
        nres++;
        if (nres == 3) m.cont_en = 1'b0;
      end
      if (nres < 4) begin
        @(negedge clk);
        k++;
      end
    end
    check("scan_result_count", nres, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("scan%0d_time", i), t[i], exp_t[i]);
      check($sformatf("scan%0d_ch", i), rc[i], exp_rc[i]);
      check($sformatf("scan%0d_result", i), rr[i], exp_rr[i]);
    end
    check("scan_busy_after_stop", int'(m.busy), 0);

    // Abort mid-CONVERT with reset
    m.ch_en = 4'b0001;
    vin[0]  = 11;
    pulse_start_m();
    wait_busy_m("abort", ok);
    repeat (45) @(negedge clk);
    check("abort_in_convert", int'(adc_sh_ctl), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(m.busy), 0);
    check("abort_sh", int'(adc_sh_ctl), 0);
    check("abort_pwm", int'(adc_dac_pwm), 0);
    check("abort_result", int'(m.result), 0);
    check("abort_result_ch", int'(m.result_ch), 0);
    check("abort_mux", int'(mux_sel), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt_valid = 0; cnt_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt_valid += int'(m.result_valid);
      cnt_busy  += int'(m.busy);
    end
    check("abort_no_valid", cnt_valid, 0);
    check("abort_stays_idle", cnt_busy, 0);

    // Single-shot rotation over ch1/ch2
    m.ch_en = 4'b0110;
    vin[1]  = 5;
    vin[2]  = 9;
    run_single("rot1", 5, 1);
    run_single("rot2", 9, 2);

    // Empty mask: start must not leave IDLE
    m.ch_en = 4'b0000;
    pulse_start_m();
    cnt_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt_busy += int'(m.busy);
    end
    check("empty_mask_busy", cnt_busy, 0);

    // Oversampling x4: conversions see 6,7,7,7 -> 27>>2 = 6
    o.ch_en = 4'b0001;
    vin_o   = 6;
    @(negedge clk) o.start = 1'b1;
    @(negedge clk) o.start = 1'b0;
    k = 0;
    while (!o.busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("osr_started", int'(o.busy), 1);
    k = 0;
    while (!o.result_valid && k < 800) begin
      if (k == 155) vin_o = 7;
      @(negedge clk);
      k++;
    end
    check("osr_valid_delay", k, 600);
    check("osr_result", int'(o.result), 6);
    check("osr_result_ch", int'(o.result_ch), 0);
    check("osr_busy_fall", int'(o.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_adc_scan.md
# sar_adc_scan

Parametrised successor to the single-channel PWM-DAC SAR ADC. It converts up to CHANNELS analog inputs through an external analog mux, one shared sample-and-hold and one shared comparator. Resolution, PWM period, sample and settle times and oversampling are all set by parameters. Supports single-shot and continuous scan over an enable mask, and reports each tagged result with a one-cycle valid strobe to the CPU I/O register block.

## Interface
- BITS, 8: SAR resolution, ≥2.
- CHANNELS, 4: number of mux inputs, ≥1; CH_W = max(1, $clog2(CHANNELS)).
- PWM_PERIOD, 255: clk cycles per DAC PWM period, ≥ 2**BITS−1.
- SAMPLE_PERIODS, 100: PWM periods spent sampling, ≥1.
- BIT_PERIODS, 100: PWM periods of DAC settle per bit, ≥1.
- OSR_LOG2, 0: averages 2**OSR_LOG2 conversions per result.
- clk  in  1  single clock; every register is on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-shot request; sampled only in IDLE.
- cont_en  in  1  continuous scan while high.
- ch_en  in  CHANNELS  channel enable mask.
- adc_cmp  in  1  comparator output; 1 means Vin ≥ Vdac. Asynchronous.
- adc_sh_ctl  out  1  0 = track (switch closed), 1 = hold.
- adc_dac_pwm  out  1  DAC PWM.
- mux_sel  out  CH_W  analog mux select.
- busy  out  1  1 whenever state ≠ IDLE.
- result  out  BITS  last averaged result.
- result_ch  out  CH_W  channel of result.
- result_valid  out  1  one-cycle strobe when result/result_ch update.

## Operation
- pwm_cnt counts 0..PWM_PERIOD−1 and wraps; it runs freely in every state.
- Boundary = the cycle with pwm_cnt == PWM_PERIOD−1. All state, tick, SAR and channel changes happen only on a boundary.
- adc_dac_pwm = (pwm_cnt < sar), decoded from registers.
- adc_cmp passes through a 2-flop synchronizer (cmp_s) before use.
- States:
  - IDLE: adc_sh_ctl = 0. sar = 0.
  - SAMPLE: adc_sh_ctl = 0.
  - CONVERT: adc_sh_ctl = 1.
- IDLE → SAMPLE on a boundary when (start_pend | cont_en) and ch_en ≠ 0.
  - start_pend is set by start in IDLE and cleared on leaving IDLE.
  - On entry, cur_ch = lowest enabled channel ≥ next_ch, wrapping at CHANNELS. next_ch resets to 0.
  - acc = 0, osr_cnt = 0.
- SAMPLE → CONVERT after SAMPLE_PERIODS boundaries. On entry sar = 1 << (BITS−1), bit_idx = BITS−1.
- CONVERT: after BIT_PERIODS boundaries for bit_idx:
  - sar[bit_idx] ← cmp_s.
  - If bit_idx > 0: sar[bit_idx−1] ← 1 and bit_idx decrements.
- Conversion end (bit 0 resolved):
  - acc (BITS+OSR_LOG2 wide) += final sar.
  - If osr_cnt < 2**OSR_LOG2−1: osr_cnt++ and return to SAMPLE on the same channel.
  - Otherwise:
    - result ← acc[BITS+OSR_LOG2−1:OSR_LOG2] (truncating average), result_ch ← cur_ch, result_valid pulses.
    - next_ch ← cur_ch+1, wrapping.
    - If cont_en is high and ch_en ≠ 0: go to SAMPLE on the next enabled channel with acc and osr_cnt cleared.
    - Else go to IDLE.
- Single-shot performs exactly one result for the first enabled channel ≥ next_ch. Successive starts therefore rotate through enabled channels.
- mux_sel = cur_ch. It is stable throughout SAMPLE and CONVERT and changes only on a boundary where SAMPLE is entered.
- ch_en is evaluated only at channel selection. Changes mid-conversion do not abort the conversion.
- cont_en falling mid-conversion lets the current result complete, then the block goes to IDLE.
- start while busy is ignored.

## Timing
- Reset values: state IDLE; pwm_cnt, sar, acc, osr_cnt, next_ch, cur_ch, result, result_ch = 0; result_valid, busy, adc_sh_ctl, adc_dac_pwm = 0; cmp sync = 0.
- rst_n low at any point aborts immediately to these values. No result is emitted.
- Start latency: leaves IDLE on the first boundary at or after the cycle following start, so 1..PWM_PERIOD cycles.
- One conversion = (SAMPLE_PERIODS + BITS·BIT_PERIODS)·PWM_PERIOD cycles.
- One result = 2**OSR_LOG2 conversions.
- result_valid is asserted in the cycle after the final boundary, for exactly 1 cycle. result and result_ch change in that same cycle.
- In continuous mode the next SAMPLE begins on the same final boundary, so there is no idle gap.
- busy falls together with result_valid in single-shot mode.

## Test plan
Parameters: BITS=4, CHANNELS=4, PWM_PERIOD=15, SAMPLE_PERIODS=2, BIT_PERIODS=2, OSR_LOG2=0 unless noted. Comparator model: adc_cmp = (vin[mux_sel] ≥ sar).

- Reset/idle: hold rst_n=0, then release and wait 100 cycles with no start → all outputs 0, busy 0, adc_dac_pwm never 1.
- Single-shot: ch_en=4'b0001, vin0=11, pulse start →
  - busy within ≤15 cycles;
  - 150 cycles after leaving IDLE, result_valid = 1 for 1 cycle with result=11, result_ch=0;
  - busy falls.
- Scan: ch_en=4'b1010, vin1=3, vin3=15, cont_en=1 → results alternate ch1=3, ch3=15, ch1=3 with valid pulses exactly 150 cycles apart; mux_sel changes only at boundaries.
- Extremes and duty: vin0=0 → result 0; vin0=15 → result 15. adc_dac_pwm high for exactly sar cycles of each 15-cycle period during CONVERT.
- Oversampling: OSR_LOG2=2, vin0 toggles 6,7,7,7 across conversions → result=(27>>2)=6, 600 cycles per result.
- Abort and rotation: assert rst_n=0 mid-CONVERT → no result_valid and instant reset values. Then ch_en=4'b0110 with two single starts → result_ch=1 then 2. With ch_en=0, start → busy stays 0.
